// File: rtl/cdb_pkg.sv
// Shared types and constants for the CDB/ROB result arbiter.
// Imported by rr_pick and cdb_arbiter.
package cdb_pkg;

   localparam int PRF_MAX_RUN_DEFAULT = 3;

   typedef struct packed {
      logic [3:0] robid;
      logic [7:0] flags;
      logic [7:0] wbs;
      logic [7:0] value;
      logic       cdb_en;
   } fu_result_t;

   typedef struct packed {
      logic       transmit;
      logic [3:0] id;
      logic [7:0] val;
   } cdb_bus_t;

   function automatic logic [5:0] count_ones(input logic [31:0] v);
      logic [5:0] n;
      n = 6'd0;
      for (int k = 0; k < 32; k++) begin
         n = n + {5'd0, v[k]};
      end
      return n;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: searches from (ptr+1) mod N upward,
// wrapping, and returns a one-hot grant, its index and an any flag.
module rr_pick
   import cdb_pkg::*;
#(
   parameter int N  = 7,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW-1:0] w_cand;

   // Walk from farthest to nearest candidate so the nearest requester wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_cand  = '0;
      for (int k = N; k >= 1; k--) begin
         w_cand = IW'((int'(i_ptr) + k) % N);
         if (i_req[w_cand]) begin
            o_grant         = '0;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
            o_any           = 1'b1;
         end else begin
            o_any = o_any;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Single-grant arbiter for the shared CDB and ROB result path (PRF + FUs).
// Optional perf counters are enabled by defining CDB_PERF_EN.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int FU_COUNT    = 7,
   parameter int PRF_MAX_RUN = PRF_MAX_RUN_DEFAULT
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [FU_COUNT-1:0]      i_fu_req,
   input  logic [FU_COUNT-1:0][3:0] i_fu_robid,
   input  logic [FU_COUNT-1:0][7:0] i_fu_flags,
   input  logic [FU_COUNT-1:0][7:0] i_fu_wbs,
   input  logic [FU_COUNT-1:0][7:0] i_fu_value,
   input  logic [FU_COUNT-1:0]      i_fu_cdb_en,
   output logic [FU_COUNT-1:0]      o_fu_grant,
   input  logic                     i_prf_req,
   input  logic [3:0]               i_prf_id,
   input  logic [7:0]               i_prf_val,
   output logic                     o_prf_grant,
   output logic                     o_cdb_transmit,
   output logic [3:0]               o_cdb_id,
   output logic [7:0]               o_cdb_val,
   output logic                     o_rob_transmit,
   output logic [3:0]               o_rob_id,
   output logic [7:0]               o_rob_flags,
   output logic [7:0]               o_rob_wbs,
   output logic [7:0]               o_rob_value
`ifdef CDB_PERF_EN
   ,
   output logic [15:0]              o_perf_grants,
   output logic [15:0]              o_perf_conflicts
`endif
);

   localparam int            IW      = $clog2(FU_COUNT);
   localparam int            RW      = $clog2(PRF_MAX_RUN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(PRF_MAX_RUN);
   localparam logic [IW-1:0] PTR_RST = IW'(FU_COUNT - 1);

   logic [IW-1:0]       r_rr_ptr;
   logic [RW-1:0]       r_prf_run;
   cdb_bus_t            r_cdb;
   logic                r_rob_transmit;
   logic [3:0]          r_rob_id;
   logic [7:0]          r_rob_flags;
   logic [7:0]          r_rob_wbs;
   logic [7:0]          r_rob_value;

   logic [FU_COUNT-1:0] w_pick_grant;
   logic [IW-1:0]       w_pick_idx;
   logic                w_pick_any;
   logic                w_any_fu;
   logic                w_prf_win;
   logic                w_fu_win;
   fu_result_t          w_sel;

   rr_pick #(.N(FU_COUNT), .IW(IW)) u_rr_pick (
      .i_req   (i_fu_req),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   // PRF yields only once it has used its run budget while FUs are waiting.
   assign w_any_fu    = |i_fu_req;
   assign w_prf_win   = ~i_rst & i_prf_req & ~((r_prf_run == RUN_MAX) & w_any_fu);
   assign w_fu_win    = ~i_rst & ~w_prf_win & w_pick_any;
   assign o_fu_grant  = w_fu_win ? w_pick_grant : '0;
   assign o_prf_grant = w_prf_win;

   assign w_sel = '{robid:  i_fu_robid[w_pick_idx],
                    flags:  i_fu_flags[w_pick_idx],
                    wbs:    i_fu_wbs[w_pick_idx],
                    value:  i_fu_value[w_pick_idx],
                    cdb_en: i_fu_cdb_en[w_pick_idx]};

   // Register the granted source onto the CDB/ROB outputs and advance arbitration state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr_ptr       <= PTR_RST;
         r_prf_run      <= '0;
         r_cdb          <= '0;
         r_rob_transmit <= 1'b0;
         r_rob_id       <= 4'd0;
         r_rob_flags    <= 8'd0;
         r_rob_wbs      <= 8'd0;
         r_rob_value    <= 8'd0;
      end else if (w_prf_win) begin
         r_cdb          <= '{transmit: 1'b1, id: i_prf_id, val: i_prf_val};
         r_rob_transmit <= 1'b0;
         if (!w_any_fu) begin
            r_prf_run <= '0;
         end else if (r_prf_run == RUN_MAX) begin
            r_prf_run <= RUN_MAX;
         end else begin
            r_prf_run <= r_prf_run + RW'(1);
         end
      end else if (w_fu_win) begin
         r_cdb          <= '{transmit: w_sel.cdb_en, id: w_sel.wbs[3:0], val: w_sel.value};
         r_rob_transmit <= 1'b1;
         r_rob_id       <= w_sel.robid;
         r_rob_flags    <= w_sel.flags;
         r_rob_wbs      <= w_sel.wbs;
         r_rob_value    <= w_sel.value;
         r_rr_ptr       <= w_pick_idx;
         r_prf_run      <= '0;
      end else begin
         r_cdb.transmit <= 1'b0;
         r_rob_transmit <= 1'b0;
         r_prf_run      <= '0;
      end
   end

   assign o_cdb_transmit = r_cdb.transmit;
   assign o_cdb_id       = r_cdb.id;
   assign o_cdb_val      = r_cdb.val;
   assign o_rob_transmit = r_rob_transmit;
   assign o_rob_id       = r_rob_id;
   assign o_rob_flags    = r_rob_flags;
   assign o_rob_wbs      = r_rob_wbs;
   assign o_rob_value    = r_rob_value;

`ifdef CDB_PERF_EN
   logic [15:0] r_perf_grants;
   logic [15:0] r_perf_conflicts;
   logic        w_conflict;

   assign w_conflict = count_ones(32'({i_prf_req, i_fu_req})) > 6'd1;

   // Saturating event counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perf_grants    <= 16'd0;
         r_perf_conflicts <= 16'd0;
      end else begin
         if (w_fu_win && (r_perf_grants != 16'hFFFF)) begin
            r_perf_grants <= r_perf_grants + 16'd1;
         end else begin
            r_perf_grants <= r_perf_grants;
         end
         if (w_conflict && (r_perf_conflicts != 16'hFFFF)) begin
            r_perf_conflicts <= r_perf_conflicts + 16'd1;
         end else begin
            r_perf_conflicts <= r_perf_conflicts;
         end
      end
   end

   assign o_perf_grants    = r_perf_grants;
   assign o_perf_conflicts = r_perf_conflicts;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized self-checking bench for cdb_arbiter against a behavioural
// scoreboard model; perf counters are checked when CDB_PERF_EN is defined.
module tb_cdb_arbiter;

   logic           i_clk = 1'b0;
   logic           i_rst;
   logic [6:0]     fu_req;
   logic [6:0][3:0] fu_robid;
   logic [6:0][7:0] fu_flags;
   logic [6:0][7:0] fu_wbs;
   logic [6:0][7:0] fu_value;
   logic [6:0]     fu_cdb_en;
   logic [6:0]     o_fu_grant;
   logic           prf_req;
   logic [3:0]     prf_id;
   logic [7:0]     prf_val;
   logic           o_prf_grant;
   logic           o_cdb_transmit;
   logic [3:0]     o_cdb_id;
   logic [7:0]     o_cdb_val;
   logic           o_rob_transmit;
   logic [3:0]     o_rob_id;
   logic [7:0]     o_rob_flags;
   logic [7:0]     o_rob_wbs;
   logic [7:0]     o_rob_value;
`ifdef CDB_PERF_EN
   logic [15:0]    o_perf_grants;
   logic [15:0]    o_perf_conflicts;
`endif

   cdb_arbiter dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_fu_req       (fu_req),
      .i_fu_robid     (fu_robid),
      .i_fu_flags     (fu_flags),
      .i_fu_wbs       (fu_wbs),
      .i_fu_value     (fu_value),
      .i_fu_cdb_en    (fu_cdb_en),
      .o_fu_grant     (o_fu_grant),
      .i_prf_req      (prf_req),
      .i_prf_id       (prf_id),
      .i_prf_val      (prf_val),
      .o_prf_grant    (o_prf_grant),
      .o_cdb_transmit (o_cdb_transmit),
      .o_cdb_id       (o_cdb_id),
      .o_cdb_val      (o_cdb_val),
      .o_rob_transmit (o_rob_transmit),
      .o_rob_id       (o_rob_id),
      .o_rob_flags    (o_rob_flags),
      .o_rob_wbs      (o_rob_wbs),
      .o_rob_value    (o_rob_value)
`ifdef CDB_PERF_EN
      ,
      .o_perf_grants    (o_perf_grants),
      .o_perf_conflicts (o_perf_conflicts)
`endif
   );

   always #5 i_clk = ~i_clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: arbitration history and expected registered outputs.
   int         m_last   = 6;
   int         m_run    = 0;
   int         e_gidx   = -1;
   logic       e_prf    = 1'b0;
   logic [6:0] e_grant  = '0;
   logic       e_cdb_tx = 1'b0;
   logic [3:0] e_cdb_id = '0;
   logic [7:0] e_cdb_val = '0;
   logic       e_rob_tx = 1'b0;
   logic [3:0] e_rob_id = '0;
   logic [7:0] e_rob_flags = '0;
   logic [7:0] e_rob_wbs = '0;
   logic [7:0] e_rob_val = '0;
   int         e_perf_g = 0;
   int         e_perf_c = 0;

   logic [45:0] obs;
   assign obs = {o_cdb_transmit, o_cdb_id, o_cdb_val, o_rob_transmit,
                 o_rob_id, o_rob_flags, o_rob_wbs, o_rob_value};

   function automatic logic [45:0] exp_out();
      return {e_cdb_tx, e_cdb_id, e_cdb_val, e_rob_tx,
              e_rob_id, e_rob_flags, e_rob_wbs, e_rob_val};
   endfunction

   // Decide who should win this cycle from the arbitration rules.
   task automatic model_comb();
      e_gidx  = -1;
      e_prf   = 1'b0;
      e_grant = '0;
      if (i_rst !== 1'b1) begin
         if (prf_req && !(m_run == 3 && fu_req != 7'd0)) begin
            e_prf = 1'b1;
         end else begin
            for (int k = 1; k <= 7; k++) begin
               if (e_gidx < 0 && fu_req[(m_last + k) % 7]) e_gidx = (m_last + k) % 7;
            end
            if (e_gidx >= 0) e_grant[e_gidx] = 1'b1;
         end
      end
   endtask

   // Apply the clock-edge effect of the decision taken in model_comb.
   task automatic model_seq();
      if (i_rst === 1'b1) begin
         m_last = 6; m_run = 0;
         e_cdb_tx = 0; e_cdb_id = 0; e_cdb_val = 0; e_rob_tx = 0;
         e_rob_id = 0; e_rob_flags = 0; e_rob_wbs = 0; e_rob_val = 0;
         e_perf_g = 0; e_perf_c = 0;
      end else begin
         if ($countones({prf_req, fu_req}) > 1 && e_perf_c < 65535) e_perf_c++;
         if (e_prf) begin
            e_cdb_tx = 1; e_cdb_id = prf_id; e_cdb_val = prf_val; e_rob_tx = 0;
            m_run = (fu_req != 7'd0) ? ((m_run < 3) ? m_run + 1 : 3) : 0;
         end else if (e_gidx >= 0) begin
            e_cdb_tx = fu_cdb_en[e_gidx]; e_cdb_id = fu_wbs[e_gidx][3:0];
            e_cdb_val = fu_value[e_gidx]; e_rob_tx = 1;
            e_rob_id = fu_robid[e_gidx]; e_rob_flags = fu_flags[e_gidx];
            e_rob_wbs = fu_wbs[e_gidx]; e_rob_val = fu_value[e_gidx];
            m_last = e_gidx; m_run = 0;
            if (e_perf_g < 65535) e_perf_g++;
         end else begin
            e_cdb_tx = 0; e_rob_tx = 0; m_run = 0;
         end
      end
   endtask

   task automatic settle();
      #1;
      model_comb();
   endtask

   task automatic clock();
      @(posedge i_clk);
      model_seq();
      #1;
   endtask

   task automatic rand_fu(int i);
      fu_robid[i]  = 4'($urandom);
      fu_flags[i]  = 8'($urandom);
      fu_wbs[i]    = 8'($urandom);
      fu_value[i]  = 8'($urandom);
      fu_cdb_en[i] = 1'($urandom);
   endtask

   task automatic clear_inputs();
      fu_req = '0; prf_req = 1'b0;
      prf_id = 4'($urandom); prf_val = 8'($urandom);
      for (int i = 0; i < 7; i++) rand_fu(i);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      settle();
      clock();
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; fu_req = 7'h7F; prf_req = 1'b1;
      @(negedge i_clk);
      repeat (2) begin
         settle();
         if (o_fu_grant !== 7'd0 || o_prf_grant !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_grant: fu=%b prf=%b, want 0 0", o_fu_grant, o_prf_grant);
         end
         vectors++;
         clock();
         if (obs !== 46'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", obs);
         end
         vectors++;
         @(negedge i_clk);
      end
      i_rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_alternate();
      do_reset();
      clear_inputs();
      fu_req = 7'b0000101;
      fu_robid[0] = 4'h3; fu_robid[2] = 4'hC;
      for (int c = 0; c < 8; c++) begin
         settle();
         if (o_fu_grant !== e_grant || o_prf_grant !== e_prf || o_fu_grant !== ((c % 2 == 0) ? 7'b0000001 : 7'b0000100)) begin
            miscompares++;
            $display("FAIL alternate_grant: fu=%b prf=%b, want fu=%b prf=%b", o_fu_grant, o_prf_grant, e_grant, e_prf);
         end
         vectors++;
         clock();
         if (obs !== exp_out() || o_rob_transmit !== 1'b1) begin
            miscompares++;
            $display("FAIL alternate_out: got %h want %h", obs, exp_out());
         end
         vectors++;
         @(negedge i_clk);
      end
   endtask

   task automatic test_prf_run();
      do_reset();
      clear_inputs();
      fu_req[3] = 1'b1; prf_req = 1'b1;
      for (int c = 0; c < 10; c++) begin
         prf_id = 4'($urandom); prf_val = 8'($urandom);
         settle();
         if (o_fu_grant !== e_grant || o_prf_grant !== e_prf || o_prf_grant !== (c % 4 != 3)) begin
            miscompares++;
            $display("FAIL prf_run_grant: fu=%b prf=%b, want fu=%b prf=%b", o_fu_grant, o_prf_grant, e_grant, e_prf);
         end
         vectors++;
         clock();
         if (obs !== exp_out()) begin
            miscompares++;
            $display("FAIL prf_run_out: got %h want %h", obs, exp_out());
         end
         vectors++;
         @(negedge i_clk);
      end
      clear_inputs();
   endtask

   task automatic test_rob_only();
      do_reset();
      clear_inputs();
      fu_req[5] = 1'b1; fu_cdb_en[5] = 1'b0; fu_value[5] = 8'hA5;
      repeat (4) begin
         settle();
         if (o_fu_grant !== 7'b0100000 || o_prf_grant !== 1'b0) begin
            miscompares++;
            $display("FAIL rob_only_grant: fu=%b prf=%b, want fu=0100000 prf=0", o_fu_grant, o_prf_grant);
         end
         vectors++;
         clock();
         if (obs !== exp_out() || o_rob_value !== 8'hA5 || o_cdb_transmit !== 1'b0 || o_rob_transmit !== 1'b1) begin
            miscompares++;
            $display("FAIL rob_only_out: got %h want %h", obs, exp_out());
         end
         vectors++;
         @(negedge i_clk);
      end
      clear_inputs();
   endtask

   task automatic test_all_fus();
      logic [6:0] want;
      do_reset();
      clear_inputs();
      fu_req = 7'h7F;
      for (int c = 0; c < 14; c++) begin
         want = 7'd1 << (c % 7);
         settle();
         if (o_fu_grant !== e_grant || o_fu_grant !== want || o_prf_grant !== 1'b0) begin
            miscompares++;
            $display("FAIL all_fus_grant: fu=%b, want %b", o_fu_grant, want);
         end
         vectors++;
         clock();
         if (obs !== exp_out()) begin
            miscompares++;
            $display("FAIL all_fus_out: got %h want %h", obs, exp_out());
         end
         vectors++;
         @(negedge i_clk);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      logic [6:0] want_fu;
      logic       want_prf;
      clear_inputs();
      fu_req = 7'h7F; prf_req = 1'b1;
      for (int c = 0; c < 6; c++) begin
         i_rst    = (c == 2);
         want_fu  = (c == 4) ? 7'b0000001 : (c == 5) ? 7'b0000010 : e_grant;
         settle();
         if (c != 4 && c != 5) want_fu = e_grant;
         want_prf = (c == 3) ? 1'b1 : (c == 2) ? 1'b0 : e_prf;
         if (o_fu_grant !== e_grant || o_prf_grant !== e_prf || o_fu_grant !== want_fu || o_prf_grant !== want_prf) begin
            miscompares++;
            $display("FAIL reset_mid_grant c%0d: fu=%b prf=%b, want fu=%b prf=%b", c, o_fu_grant, o_prf_grant, want_fu, want_prf);
         end
         vectors++;
         clock();
         if (obs !== exp_out() || (c == 2 && obs !== 46'd0)) begin
            miscompares++;
            $display("FAIL reset_mid_out c%0d: got %h want %h", c, obs, exp_out());
         end
         vectors++;
         @(negedge i_clk);
         if (c == 3) prf_req = 1'b0;
      end
      i_rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_random();
      do_reset();
      clear_inputs();
      for (int c = 0; c < 400; c++) begin
         settle();
         if (o_fu_grant !== e_grant || o_prf_grant !== e_prf) begin
            miscompares++;
            $display("FAIL random_grant c%0d: fu=%b prf=%b, want fu=%b prf=%b", c, o_fu_grant, o_prf_grant, e_grant, e_prf);
         end
         vectors++;
         clock();
         if (obs !== exp_out()) begin
            miscompares++;
            $display("FAIL random_out c%0d: got %h want %h", c, obs, exp_out());
         end
         vectors++;
         @(negedge i_clk);
         // Hold data while pending; refresh after grant; occasionally flush.
         for (int i = 0; i < 7; i++) begin
            if (!fu_req[i] || e_gidx == i) begin
               fu_req[i] = ($urandom_range(0, 2) == 0);
               rand_fu(i);
            end else if ($urandom_range(0, 15) == 0) begin
               fu_req[i] = 1'b0;
            end
         end
         if (!prf_req || e_prf) begin
            prf_req = ($urandom_range(0, 1) == 0);
            prf_id = 4'($urandom); prf_val = 8'($urandom);
         end
      end
      clear_inputs();
   endtask

`ifdef CDB_PERF_EN
   task automatic test_perf();
      do_reset();
      clear_inputs();
      fu_req = 7'b0010010;
      repeat (10) begin
         settle();
         clock();
         @(negedge i_clk);
      end
      if (o_perf_conflicts !== 16'd10 || o_perf_grants !== 16'(e_perf_g)) begin
         miscompares++;
         $display("FAIL perf: grants=%0d conflicts=%0d, want %0d 10", o_perf_grants, o_perf_conflicts, e_perf_g);
      end
      vectors++;
      clear_inputs();
   endtask
`endif

   initial begin
      i_rst = 1'b1;
      clear_inputs();
      test_reset();
      test_alternate();
      test_prf_run();
      test_rob_only();
      test_all_fus();
      test_reset_mid();
      test_random();
`ifdef CDB_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
